// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and instruction field positions for seq_cpu_core
package cpu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 2;
    localparam int RD_HI = 1;
    localparam int RD_LO = 0;

    // 2-bit two's-complement offset widened to the 8-bit address space
    function automatic logic [7:0] sext_imm(input logic [1:0] imm);
        return {{6{imm[1]}}, imm};
    endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - data memory with one synchronous write port and two combinational read ports
module data_mem #(
    parameter int DMEM_DEPTH = 16,
    localparam int AW = $clog2(DMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    logic [7:0] mem [DMEM_DEPTH];

    // Each word powers up holding its own index so loads are observable without prior stores
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                mem[i] <= 8'(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/seq_cpu_core.sv
// rtl/seq_cpu_core.sv - two-cycle-per-instruction 8-bit core running ADD/LOAD/STORE/STOP from a combinational ROM
module seq_cpu_core
    import cpu_pkg::*;
#(
    parameter int DMEM_DEPTH = 16,
    localparam int AW = $clog2(DMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    output logic [7:0]    address,
    input  logic [7:0]    instruction,
    output logic          busy,
    output logic          halted,
    output logic [31:0]   regs,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] s [4];

    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] ea;
    logic [7:0] load_data;
    logic       mem_we;

    assign op = ir[OP_HI:OP_LO];
    assign rs = ir[RS_HI:RS_LO];
    assign rt = ir[RT_HI:RT_LO];
    assign rd = ir[RD_HI:RD_LO];
    assign ea = s[rs] + sext_imm(rd);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = EXECUTE;
            EXECUTE: state_next = (op == OP_STOP) ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == FETCH) || (state == EXECUTE);
        halted = (state == HALT);
    end

    // Right-hand sides sample the old register values, so rd may alias rs or rt
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pc <= 8'h00;
            ir <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                s[i] <= 8'h00;
            end
        end else begin
            if (state == FETCH) begin
                ir <= instruction;
            end
            if (state == EXECUTE) begin
                case (op)
                    OP_ADD:  s[rd] <= s[rs] + s[rt];
                    OP_LOAD: s[rt] <= load_data;
                    default: ;
                endcase
                if (op != OP_STOP) begin
                    pc <= pc + 8'd1;
                end
            end
        end
    end

    assign mem_we = (state == EXECUTE) && (op == OP_STORE);

    data_mem #(.DMEM_DEPTH(DMEM_DEPTH)) u_dmem (
        .clk      (clk),
        .clear    (clear),
        .we       (mem_we),
        .waddr    (ea[AW-1:0]),
        .wdata    (s[rt]),
        .raddr    (ea[AW-1:0]),
        .rdata    (load_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign address = pc;
    assign regs    = {s[3], s[2], s[1], s[0]};

endmodule

// File: tb/tb_seq_cpu_core.sv
// tb/tb_seq_cpu_core.sv - directed table, corner sequences and random programs against an instruction-level model
module tb_seq_cpu_core;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  address;
    logic [7:0]  instruction;
    logic        busy;
    logic        halted;
    logic [31:0] regs;
    logic [3:0]  dbg_addr = 4'd0;
    logic [7:0]  dbg_data;

    logic [7:0]  rom [256];
    assign instruction = rom[address];

    always #5 clk = ~clk;

    seq_cpu_core #(.DMEM_DEPTH(16)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .address     (address),
        .instruction (instruction),
        .busy        (busy),
        .halted      (halted),
        .regs        (regs),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    int total  = 0;
    int passed = 0;

    int m_s [4];
    int m_dm [16];
    int m_k;
    int m_pc;

    typedef struct {
        logic [0:7][7:0] prog;
        int              len;
        logic [31:0]     regs;
        logic [7:0]      addr;
        int              edges;
        logic [3:0]      dm_idx;
        logic [7:0]      dm_val;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset(input bit verify);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        #1;
        if (verify) begin
            check("reset_address", {24'h0, address}, 32'h0);
            check("reset_regs", regs, 32'h0);
            check("reset_busy", {31'h0, busy}, 32'h0);
            check("reset_halted", {31'h0, halted}, 32'h0);
            for (int i = 0; i < 16; i++) begin
                dbg_addr = 4'(i);
                #1;
                check($sformatf("reset_dmem[%0d]", i), {24'h0, dbg_data}, 32'(i));
            end
        end
        @(negedge clk);
        clear = 1'b1;
    endtask

    task automatic load_prog(input logic [0:7][7:0] p, input int len);
        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
        for (int i = 0; i < len; i++) rom[i] = p[i];
    endtask

    // Instruction-level interpreter over the ROM contents, from the reset state
    task automatic model_run();
        logic [7:0] ins;
        int op, rs, rt, rd, imm, ea;
        for (int i = 0; i < 4; i++) m_s[i] = 0;
        for (int i = 0; i < 16; i++) m_dm[i] = i;
        m_pc = 0;
        m_k  = 0;
        while (m_k < 300) begin
            ins = rom[m_pc];
            m_k++;
            op  = int'(ins[7:6]);
            rs  = int'(ins[5:4]);
            rt  = int'(ins[3:2]);
            rd  = int'(ins[1:0]);
            if (op == 3) break;
            imm = (rd >= 2) ? rd - 4 : rd;
            ea  = (m_s[rs] + imm + 256) % 256;
            if (op == 0) m_s[rd] = (m_s[rs] + m_s[rt]) % 256;
            else if (op == 1) m_s[rt] = m_dm[ea % 16];
            else m_dm[ea % 16] = m_s[rt];
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic run(input bit noise, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (!halted && edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            if (noise) start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic compare_model(input string tag, input int edges);
        logic [31:0] e;
        e = {8'(m_s[3]), 8'(m_s[2]), 8'(m_s[1]), 8'(m_s[0])};
        check({tag, "_regs"}, regs, e);
        check({tag, "_address"}, {24'h0, address}, 32'(m_pc));
        check({tag, "_halted"}, {31'h0, halted}, 32'h1);
        check({tag, "_edges"}, 32'(edges), 32'(2 * m_k));
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check($sformatf("%s_dmem[%0d]", tag, i), {24'h0, dbg_data}, 32'(m_dm[i]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int edges;
        logic [7:0] dbl [5];
        logic [0:7][7:0] p;

        vecs[0] = '{prog: {8'h49, 8'h65, 8'h1B, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, len: 4,
                    regs: 32'h03010200, addr: 8'd3, edges: 8, dm_idx: 4'd3, dm_val: 8'h03};
        vecs[1] = '{prog: {8'h45, 8'h16, 8'h2B, 8'hBE, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, len: 5,
                    regs: 32'h04020100, addr: 8'd4, edges: 10, dm_idx: 4'd2, dm_val: 8'h04};
        vecs[2] = '{prog: {8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hC0}, len: 7,
                    regs: 32'h000000E0, addr: 8'd6, edges: 14, dm_idx: 4'd15, dm_val: 8'h0F};
        vecs[3] = '{prog: {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, len: 1,
                    regs: 32'h00000000, addr: 8'd0, edges: 2, dm_idx: 4'd0, dm_val: 8'h00};

        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
        do_reset(1'b1);

        for (int v = 0; v < 4; v++) begin
            do_reset(1'b0);
            load_prog(vecs[v].prog, vecs[v].len);
            model_run();
            run(v == 0, edges);
            check($sformatf("vec%0d_regs", v), regs, vecs[v].regs);
            check($sformatf("vec%0d_address", v), {24'h0, address}, {24'h0, vecs[v].addr});
            check($sformatf("vec%0d_edges", v), 32'(edges), 32'(vecs[v].edges));
            check($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
            dbg_addr = vecs[v].dm_idx;
            #1;
            check($sformatf("vec%0d_dmem", v), {24'h0, dbg_data}, {24'h0, vecs[v].dm_val});
            compare_model($sformatf("vec%0d", v), edges);
        end

        // s0 after each instruction of the wrap program
        dbl = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};
        do_reset(1'b0);
        load_prog(vecs[2].prog, vecs[2].len);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("wrap_load_s0", {24'h0, regs[7:0]}, 32'h0F);
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("wrap_add%0d_s0", i), {24'h0, regs[7:0]}, {24'h0, dbl[i]});
        end
        repeat (2) @(posedge clk);
        #1;
        check("wrap_halted", {31'h0, halted}, 32'h1);

        // clear asserted in the middle of the STORE's execute cycle
        do_reset(1'b0);
        load_prog(vecs[1].prog, vecs[1].len);
        dbg_addr = 4'd2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midop_busy_before", {31'h0, busy}, 32'h1);
        check("midop_regs_before", regs, 32'h04020100);
        #2;
        clear = 1'b0;
        #1;
        check("midop_dmem2", {24'h0, dbg_data}, 32'h02);
        check("midop_regs", regs, 32'h0);
        check("midop_address", {24'h0, address}, 32'h0);
        check("midop_busy", {31'h0, busy}, 32'h0);
        check("midop_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midop_idle_hold", {30'h0, halted, busy}, 32'h0);
        run(1'b0, edges);
        check("rerun_regs", regs, 32'h04020100);
        check("rerun_edges", 32'(edges), 32'd10);
        dbg_addr = 4'd2;
        #1;
        check("rerun_dmem2", {24'h0, dbg_data}, 32'h04);

        for (int r = 0; r < 20; r++) begin
            int k;
            do_reset(1'b0);
            k = $urandom_range(1, 24);
            for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
            for (int i = 0; i < k - 1; i++) begin
                rom[i] = {2'($urandom_range(0, 2)), 6'($urandom)};
            end
            p = '0;
            model_run();
            run(1'b1, edges);
            compare_model($sformatf("rand%0d", r), edges);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_cpu_core.md
# seq_cpu_core

Multi-cycle 8-bit processor core that consumes the 8-bit instruction stream from the instruction ROM. It drives the ROM `address` and reads back `instruction`, then executes ADD/LOAD/STORE/STOP against a 4-entry register file (s0–s3) and an internal data memory. It sits directly on the ROM's read port. It exposes register and memory state for bench checking and for display.

## Interface
Parameters:
- `DMEM_DEPTH`, default 16: data-memory entries (power of two); word i resets to value i.

Ports:
- `clk` in 1: single clock, rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `start` in 1: level, sampled in IDLE only; begins execution from address 0.
- `address` out 8: instruction ROM address; equals PC.
- `instruction` in 8: ROM data; combinational response to `address`.
- `busy` out 1: high in FETCH/EXECUTE.
- `halted` out 1: high in HALT.
- `regs` out 32: {s3,s2,s1,s0}.
- `dbg_addr` in log2(DMEM_DEPTH): data-memory debug read index.
- `dbg_data` out 8: combinational read of dmem[`dbg_addr`].

## Operation
Instruction fields:
- op = [7:6]
- rs = [5:4]
- rt = [3:2]
- rd/imm = [1:0]; imm is signed 2-bit (00=0, 01=+1, 10=−2, 11=−1).
- EA = (s[rs] + sext8(imm)) mod 256; dmem index = EA[log2(DMEM_DEPTH)−1:0].

Opcodes:
- op 00 ADD: s[rd] ← (s[rs] + s[rt]) mod 256; carry discarded.
- op 01 LOAD: s[rt] ← dmem[EA].
- op 10 STORE: dmem[EA] ← s[rt].
- op 11 STOP: no state change; enter HALT. Low bits are ignored.

States:
- IDLE: `start`=1 → FETCH.
- FETCH: IR ← `instruction` at `address`=PC → EXECUTE.
- EXECUTE: perform op from IR. Non-STOP ops: PC ← PC+1 (wraps 255→0) → FETCH. STOP: PC holds → HALT.
- HALT: terminal; only `clear` leaves it.

Other rules:
- Operands are read before write, so rd=rs is legal (e.g. s0+s0→s0 doubles).
- `start` is ignored outside IDLE.

Reset values (asynchronous, immediate, including mid-instruction):
- state=IDLE, PC=0 (`address`=0), IR=0.
- s0..s3=0, dmem[i]=i.
- `busy`=0, `halted`=0.

## Timing
- `start` is sampled high in IDLE at edge N: FETCH during cycle N+1, EXECUTE during N+2.
- Each instruction takes exactly 2 cycles.
- Register and dmem writes become visible on `regs` and `dbg_data` after the EXECUTE edge.
- A STORE followed by a LOAD of the same EA returns the stored value; there are no hazards because execution is strictly sequential.
- For a K-instruction program ending in STOP, `halted` rises after the 2K-th edge following the `start` edge. `address` then holds the STOP address.
- `address` is registered (PC) and is stable for the whole FETCH cycle. The ROM is combinational, so there are no wait states.
- Releasing `clear` mid-cycle has no effect until the next rising edge.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants `OP_ADD=2'b00`, `OP_LOAD=2'b01`, `OP_STORE=2'b10`, `OP_STOP=2'b11`;
  - the state enum {IDLE, FETCH, EXECUTE, HALT};
  - field position constants.
- Sub-module `data_mem`:
  - DMEM_DEPTH×8 storage;
  - async active-low init to index values;
  - one synchronous write port;
  - two combinational read ports (EA and `dbg_addr`).
- The register file, PC, IR and FSM live in `seq_cpu_core`.

## Test plan
1. Reset: assert `clear` → `address`=0, `regs`=0x00000000, `busy`=0, `halted`=0, `dbg_data`@i = i for all i.
2. Basic program: ROM 0:01001001, 1:01100101, 2:00011011, 3:11000000; pulse `start`.
   - After 8 edges: `regs`=0x03010200, `halted`=1, `address`=3.
   - `start` pulses during execution change nothing.
3. Store with negative offset: ROM 01000101, 00010110, 00101011, 10111110, 11000000.
   - s3=4; dmem[2]=0x04 (`dbg_addr`=2).
   - All other dmem words are unchanged.
4. EA and add wrap: ROM 01000011 (s0←dmem[0xFF→15]=0x0F), then five × 00000000, then STOP.
   - s0 sequence: 0x1E, 0x3C, 0x78, 0xF0, final 0xE0.
5. Reset mid-op: assert `clear` during EXECUTE of test 3's STORE.
   - Immediately: dmem[2]=2, `regs`=0, `address`=0, state IDLE.
   - Rerun after release matches test 3.
6. Immediate STOP at address 0: `halted`=1 two edges after `start`; `regs`=0, `address`=0.
